apb_completer: RTL and testbench

APB_COMPLETER -- requirements
Module: apb_completer

---
 rtl/apb_completer.sv | 248 ++++++++++++++++++++++++
 tb/tb_apb_completer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_completer.sv
// -----------------------------------------------------------------------------
// apb_completer
//
// APB completer with a small register file, a configurable number of wait
// states, and a read-only transfer counter in the top register slot.
//
// Address map (byte addresses, word aligned):
//   4*i, i = 0 .. NUM_REGS-2  : read/write registers (register 0 drives ctrl_o)
//   4*(NUM_REGS-1)            : read-only count of completed transfers
//
// Parameters:
//   ADDR_WIDTH  : width of paddr (at least 2)
//   DATA_WIDTH  : width of pwdata, prdata and every register
//   NUM_REGS    : number of registers, minimum 2
//   WAIT_CYCLES : wait states inserted before pready, 0..15
//
// Ports:
//   pclk     in   clock, all state changes on the rising edge
//   presetn  in   asynchronous active-low reset
//   psel     in   completer selected
//   penable  in   access phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   pready   out  transfer completes this cycle
//   prdata   out  read data, zero unless pready=1 on a valid read
//   pslverr  out  error response, zero unless pready=1
//   ctrl_o   out  current value of register 0
// -----------------------------------------------------------------------------
module apb_completer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] ctrl_o
);

  // Register index width; the index is taken from address bits [IDX_W+1:2].
  localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  // Address is zero-extended to at least 33 bits so that 4*NUM_REGS can be
  // compared without truncation, whatever ADDR_WIDTH is.
  localparam int EXT_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH + 1 : 33;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    WAIT_ST = 2'd1,
    RESP_ST = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   xfer_cnt_q, xfer_cnt_d;

  logic                    setup;
  logic [EXT_W-1:0]        addr_ext;
  logic [IDX_W-1:0]        idx;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    ro_write;
  logic                    err;
  logic                    complete;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Read/write register contents, one packed slice per register.
  logic [NUM_REGS-2:0][DATA_WIDTH-1:0] rw_words;

  // A setup phase is only recognised from IDLE; psel+penable seen in IDLE
  // without a preceding setup is ignored.
  assign setup = (state_q == IDLE_ST) && psel && !penable;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE_ST: begin
        if (setup) begin
          state_d = (WAIT_CYCLES > 0) ? WAIT_ST : RESP_ST;
        end
      end
      WAIT_ST: begin
        if (!psel) begin
          state_d = IDLE_ST;
        end else if (wait_cnt_q <= 4'd1) begin
          // The counter reaches zero on this edge.
          state_d = RESP_ST;
        end
      end
      RESP_ST: begin
        state_d = IDLE_ST;
      end
      default: begin
        state_d = IDLE_ST;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. prdata/pslverr are forced to zero outside RESP_ST so the bus
  // never sees stale data, and they fall to zero as soon as reset asserts.
  // ---------------------------------------------------------------------------
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (state_q == RESP_ST) begin
      pready  = 1'b1;
      pslverr = err;
      prdata  = (!write_q && !err) ? rd_word : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait counter and setup-phase capture. Address, direction and data are held
  // from the setup cycle so later bus changes cannot affect the transfer.
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      IDLE_ST: begin
        if (setup) begin
          wait_cnt_d = 4'(WAIT_CYCLES);
          addr_d     = paddr;
          write_d    = pwrite;
          wdata_d    = pwdata;
        end
      end
      WAIT_ST: begin
        wait_cnt_d = psel ? (wait_cnt_q - 4'd1) : 4'd0;
      end
      default: begin
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode and error flag, all from the captured setup values.
  // ---------------------------------------------------------------------------
  assign addr_ext     = EXT_W'(addr_q);
  assign idx          = addr_ext[2 +: IDX_W];
  assign misaligned   = (addr_ext[1:0] != 2'b00);
  assign out_of_range = (addr_ext >= EXT_W'(4 * NUM_REGS));
  assign ro_write     = write_q && (idx == IDX_W'(NUM_REGS - 1));
  assign err          = misaligned || out_of_range || ro_write;

  // A transfer counts as completed whenever psel is still high in RESP_ST;
  // the register write additionally needs penable and a clean decode.
  assign complete = (state_q == RESP_ST) && psel;
  assign wr_fire  = complete && penable && write_q && !err;

  // ---------------------------------------------------------------------------
  // Read/write registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_rw_reg
      logic [DATA_WIDTH-1:0] reg_q, reg_d;

      assign reg_d = (wr_fire && (idx == IDX_W'(gi))) ? wdata_q : reg_q;

      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rw_words[gi] = reg_q;
    end
  endgenerate

  assign ctrl_o = rw_words[0];

  // ---------------------------------------------------------------------------
  // Transfer counter in the top register slot. Wraps naturally at the data
  // width. A read of this slot sees the value before its own increment because
  // prdata is driven from the current register value during RESP_ST.
  // ---------------------------------------------------------------------------
  assign xfer_cnt_d = complete ? (xfer_cnt_q + 1'b1) : xfer_cnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux. Indices beyond NUM_REGS-1 are always out of range and never
  // reach prdata, so the counter is a safe default.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = xfer_cnt_q;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_word = rw_words[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// -----------------------------------------------------------------------------
// tb_apb_completer
//
// Three completers with 0, 1 and 3 wait states share one clock and are driven
// one at a time. A behavioural model (register array + transfer count, using
// the address-map and error rules directly) predicts every response.
// -----------------------------------------------------------------------------
module tb_apb_completer;

  localparam int NDUT = 3;

  logic        pclk;
  logic        presetn [NDUT];
  logic        psel    [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [7:0]  paddr   [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic        pready  [NDUT];
  logic [31:0] prdata  [NDUT];
  logic        pslverr [NDUT];
  logic [31:0] ctrl_o  [NDUT];

  // Behavioural model
  logic [31:0] m_regs [NDUT][8];
  logic [31:0] m_cnt  [NDUT];

  int checks = 0;
  int errors = 0;

  apb_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]),
    .prdata(prdata[0]), .pslverr(pslverr[0]), .ctrl_o(ctrl_o[0])
  );

  apb_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(1)) u_dut1 (
    .pclk(pclk), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]),
    .prdata(prdata[1]), .pslverr(pslverr[1]), .ctrl_o(ctrl_o[1])
  );

  apb_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(3)) u_dut2 (
    .pclk(pclk), .presetn(presetn[2]), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .pready(pready[2]),
    .prdata(prdata[2]), .pslverr(pslverr[2]), .ctrl_o(ctrl_o[2])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) m_regs[k][i] = 32'h0;
    m_cnt[k] = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Full APB transfer on DUT k. Entered and left just after a rising edge, so
  // consecutive calls produce back-to-back transfers with no idle cycle.
  task automatic do_xfer(input int k, input bit wr, input logic [7:0] addr,
                         input logic [31:0] wdata);
    int          cyc;
    bit          got;
    bit          err;
    logic [31:0] exp_rd;
    logic [31:0] obs_rd;
    logic        obs_err;

    psel[k]    = 1'b1;
    penable[k] = 1'b0;
    pwrite[k]  = wr;
    paddr[k]   = addr;
    pwdata[k]  = wdata;
    @(posedge pclk);
    #1;
    penable[k] = 1'b1;
    // Bus address/data after setup must be ignored by the completer.
    paddr[k]   = 8'($urandom);
    pwdata[k]  = $urandom;

    cyc = 0;
    got = 1'b0;
    while (cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (pready[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
      chk("wait_prdata_zero", prdata[k], 32'h0);
      chk("wait_pslverr_zero", 32'(pslverr[k]), 32'h0);
      @(posedge pclk);
      #1;
    end
    chk("pready_seen", 32'(got), 32'h1);
    if (!got) begin
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
      return;
    end
    chk("access_cycles", 32'(cyc), 32'(wait_of(k) + 1));

    err    = (addr[1:0] != 2'b00) || (addr >= 8'd32) || (wr && (addr == 8'h1C));
    exp_rd = 32'h0;
    if (!wr && !err) exp_rd = (addr == 8'h1C) ? m_cnt[k] : m_regs[k][addr[4:2]];
    obs_rd  = prdata[k];
    obs_err = pslverr[k];
    chk("pslverr", 32'(obs_err), 32'(err));
    chk("prdata", obs_rd, exp_rd);

    @(posedge pclk);
    #1;
    if (wr && !err) m_regs[k][addr[4:2]] = wdata;
    m_cnt[k]   = m_cnt[k] + 32'h1;
    psel[k]    = 1'b0;
    penable[k] = 1'b0;
    chk("ctrl_o", ctrl_o[k], m_regs[k][0]);
    $display("xfer dut%0d %s addr=%h wdata=%h prdata=%h pslverr=%0d cycles=%0d",
             k, wr ? "WR" : "RD", addr, wdata, obs_rd, obs_err, cyc);
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    int         pick;
    pick = int'($urandom_range(0, 9));
    if (pick == 6) begin
      a = 8'($urandom_range(0, 63));
      if (a[1:0] == 2'b00) a[0] = 1'b1;
    end else if (pick == 7) begin
      a = 8'(32 + 4 * $urandom_range(0, 55));
    end else begin
      a = 8'(4 * $urandom_range(0, 7));
    end
    return a;
  endfunction

  initial begin
    int cyc;
    bit got;

    for (int k = 0; k < NDUT; k++) begin
      presetn[k] = 1'b1;
      psel[k]    = 1'b0;
      penable[k] = 1'b0;
      pwrite[k]  = 1'b0;
      paddr[k]   = 8'h0;
      pwdata[k]  = 32'h0;
      model_reset(k);
    end
    #1;
    for (int k = 0; k < NDUT; k++) presetn[k] = 1'b0;
    #21;
    // Reset state
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_pready", 32'(pready[k]), 32'h0);
      chk("rst_prdata", prdata[k], 32'h0);
      chk("rst_pslverr", 32'(pslverr[k]), 32'h0);
      chk("rst_ctrl_o", ctrl_o[k], 32'h0);
    end
    for (int k = 0; k < NDUT; k++) presetn[k] = 1'b1;
    @(posedge pclk);
    #1;

    // One wait state: write then read register 0
    do_xfer(1, 1'b1, 8'h00, 32'hA5A5_0001);
    chk("ctrl_o_a5a5", ctrl_o[1], 32'hA5A5_0001);
    do_xfer(1, 1'b0, 8'h00, 32'h0);

    // Zero wait states, back-to-back write/read of 0x04 then the counter
    do_xfer(0, 1'b1, 8'h04, 32'h1234_5678);
    do_xfer(0, 1'b0, 8'h04, 32'h0);
    do_xfer(0, 1'b0, 8'h1C, 32'h0);

    // Error responses, then confirm nothing changed
    do_xfer(1, 1'b1, 8'h1C, 32'hDEAD_BEEF);
    do_xfer(1, 1'b0, 8'h20, 32'h0);
    do_xfer(1, 1'b0, 8'h02, 32'h0);
    do_xfer(1, 1'b0, 8'h00, 32'h0);
    do_xfer(1, 1'b0, 8'h1C, 32'h0);

    // Access without setup in IDLE is ignored
    psel[1]    = 1'b1;
    penable[1] = 1'b1;
    pwrite[1]  = 1'b1;
    paddr[1]   = 8'h04;
    pwdata[1]  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("nosetup_pready", 32'(pready[1]), 32'h0);
      @(posedge pclk);
      #1;
    end
    psel[1]    = 1'b0;
    penable[1] = 1'b0;
    idle(1);
    do_xfer(1, 1'b0, 8'h04, 32'h0);
    do_xfer(1, 1'b0, 8'h1C, 32'h0);

    // psel dropped during the wait states of a write to 0x08
    psel[2]    = 1'b1;
    penable[2] = 1'b0;
    pwrite[2]  = 1'b1;
    paddr[2]   = 8'h08;
    pwdata[2]  = 32'h0BAD_0BAD;
    @(posedge pclk);
    #1;
    penable[2] = 1'b1;
    @(negedge pclk);
    chk("drop_pready", 32'(pready[2]), 32'h0);
    @(posedge pclk);
    #1;
    psel[2]    = 1'b0;
    penable[2] = 1'b0;
    idle(2);
    do_xfer(2, 1'b0, 8'h08, 32'h0);
    do_xfer(2, 1'b0, 8'h1C, 32'h0);

    // Reset asserted between edges while a write sits in its response cycle
    psel[1]    = 1'b1;
    penable[1] = 1'b0;
    pwrite[1]  = 1'b1;
    paddr[1]   = 8'h0C;
    pwdata[1]  = 32'h5555_AAAA;
    @(posedge pclk);
    #1;
    penable[1] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (pready[1] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge pclk);
      #1;
    end
    chk("rstmid_pready_seen", 32'(got), 32'h1);
    presetn[1] = 1'b0;
    #1;
    chk("rstmid_pready", 32'(pready[1]), 32'h0);
    chk("rstmid_prdata", prdata[1], 32'h0);
    chk("rstmid_pslverr", 32'(pslverr[1]), 32'h0);
    chk("rstmid_ctrl_o", ctrl_o[1], 32'h0);
    model_reset(1);
    psel[1]    = 1'b0;
    penable[1] = 1'b0;
    @(posedge pclk);
    #1;
    presetn[1] = 1'b1;
    idle(1);
    do_xfer(1, 1'b0, 8'h0C, 32'h0);
    do_xfer(1, 1'b0, 8'h1C, 32'h0);

    // Randomized traffic on every completer
    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 25; n++) begin
        do_xfer(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        idle(int'($urandom_range(0, 2)));
      end
      do_xfer(k, 1'b0, 8'h1C, 32'h0);
    end

    // Counter wrap: preload all ones, read it, then read the wrapped value
    force u_dut0.xfer_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut0.xfer_cnt_q;
    m_cnt[0] = 32'hFFFF_FFFF;
    do_xfer(0, 1'b0, 8'h1C, 32'h0);
    do_xfer(0, 1'b0, 8'h1C, 32'h0);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
